// File: rtl/vga_timing_gen_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
// Screen coordinates travel to the framebuffer as a packed {x, y} pair.
package vga_timing_gen_pkg;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } screen_xy_t;

  localparam int VGA_CLK_DIV    = 2;
  localparam int VGA_H_ACTIVE   = 640;
  localparam int VGA_H_FP       = 16;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_BP       = 48;
  localparam int VGA_H_TOTAL    = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACTIVE   = 480;
  localparam int VGA_V_FP       = 10;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_BP       = 33;
  localparam int VGA_V_TOTAL    = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_FB_LATENCY = 1;

  // {hs, vs, valid} while nothing is being displayed
  localparam logic [2:0] SYNC_IDLE = 3'b110;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Link between the raster generator, the framebuffer and the VGA pins.
// master = timing generator, slave = framebuffer / pin consumer.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  screen_xy_t coords;
  logic       coords_valid;
  logic       new_frame;
  logic [2:0] color_in;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic [2:0] vga_rgb;

  modport master (
    output coords, coords_valid, new_frame, vga_hs, vga_vs, vga_blank_n, vga_rgb,
    input  color_in
  );

  modport slave (
    input  coords, coords_valid, new_frame, vga_hs, vga_vs, vga_blank_n, vga_rgb,
    output color_in
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Register shift line that reloads INIT on reset; matches sync/blank to the
// framebuffer read latency.
module vga_sync_delay
  import vga_timing_gen_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = SYNC_IDLE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] line [DEPTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) line[i] <= INIT;
    end else begin
      line[0] <= d;
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign q = line[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, sync decode, new_frame pulse,
// and the pin register that joins the framebuffer colour with delayed sync/blank.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV    = VGA_CLK_DIV,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int FB_LATENCY = VGA_FB_LATENCY
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Last line before vsync; its final pixel step lands on VS_START
  localparam logic [9:0] NF_LINE  = 10'(V_ACTIVE + V_FP - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_ce;
  logic [9:0]       hcnt;
  logic [9:0]       vcnt;
  logic             hs_raw;
  logic             vs_raw;
  logic             valid_raw;
  logic [2:0]       sync_d;

  assign pix_ce = (div_cnt == DIV_LAST);

  always_ff @(posedge Clk) begin
    if (Reset || pix_ce) div_cnt <= '0;
    else                 div_cnt <= div_cnt + DIV_ONE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Registered so the pulse is seen together with the first vsync line
  always_ff @(posedge Clk) begin
    if (Reset) vga.new_frame <= 1'b0;
    else       vga.new_frame <= pix_ce && (hcnt == H_LAST) && (vcnt == NF_LINE);
  end

  assign hs_raw    = !((hcnt >= HS_START) && (hcnt < HS_END));
  assign vs_raw    = !((vcnt >= VS_START) && (vcnt < VS_END));
  assign valid_raw = (hcnt < H_ACT) && (vcnt < V_ACT);

  assign vga.coords       = {hcnt, vcnt};
  assign vga.coords_valid = valid_raw;

  vga_sync_delay #(
    .WIDTH (3),
    .DEPTH (FB_LATENCY),
    .INIT  (SYNC_IDLE)
  ) u_sync_delay (
    .Clk   (Clk),
    .Reset (Reset),
    .d     ({hs_raw, vs_raw, valid_raw}),
    .q     (sync_d)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vga.vga_hs      <= 1'b1;
      vga.vga_vs      <= 1'b1;
      vga.vga_blank_n <= 1'b0;
      vga.vga_rgb     <= 3'b000;
    end else begin
      vga.vga_hs      <= sync_d[2];
      vga.vga_vs      <= sync_d[1];
      vga.vga_blank_n <= sync_d[0];
      vga.vga_rgb     <= sync_d[0] ? vga.color_in : 3'b000;
    end
  end

endmodule
